// File: rtl/hex_digit_counter_pkg.sv
// Shared constants for the hex digit counter: active-low glyph table for 0-F
// and segment-vector layout constants.
package hex_digit_counter_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 7;

  // Active-low {dp, g, f, e, d, c, b, a}; DP is always off in the table.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] glyph_of(input logic [3:0] value);
    return GLYPH_TABLE[value];
  endfunction

endpackage

// File: rtl/hex_digit_counter_hex_to_7seg.sv
// Combinational hex-to-7-segment decoder with decimal point, output polarity
// selected by SEG_ACTIVE_LOW (1 = common anode, 0 = all bits inverted).
module hex_to_7seg
  import hex_digit_counter_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] value_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_al;
  logic [7:0] glyph;

  assign glyph = glyph_of(value_i);

  always_comb begin
    seg_al         = SEG_BLANK;
    seg_al[6:0]    = glyph[6:0];
    seg_al[DP_BIT] = ~dp_i;
  end

  generate
    if (SEG_ACTIVE_LOW != 0) begin : g_active_low
      assign seg_o = seg_al;
    end else begin : g_active_high
      assign seg_o = ~seg_al;
    end
  endgenerate

endmodule

// File: rtl/hex_digit_counter.sv
// 4-bit up/down counter with parallel load driving one 7-segment hex digit.
// Optional terminal-count output Tc for cascading is enabled by HEX_DIGIT_COUNTER_TC_EN.
module hex_digit_counter
  import hex_digit_counter_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Load,
  input  logic       Count_en,
  input  logic       Up,
  input  logic [3:0] Count_in,
  input  logic       DP,
  output logic [7:0] Segment
`ifdef HEX_DIGIT_COUNTER_TC_EN
  ,
  output logic       Tc
`endif
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load beats counting; counting wraps naturally in 4 bits.
  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = Count_in;
    end else if (Count_en) begin
      count_d = Up ? (count_q + 4'd1) : (count_q - 4'd1);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  hex_to_7seg #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_hex_to_7seg (
    .value_i(count_q),
    .dp_i   (DP),
    .seg_o  (Segment)
  );

`ifdef HEX_DIGIT_COUNTER_TC_EN
  // Gated by nReset so a held-reset digit never requests a carry downstream.
  assign Tc = nReset & Count_en & ~Load &
              ((Up & (count_q == 4'hF)) | (~Up & (count_q == 4'h0)));
`endif

endmodule

// File: tb/tb_hex_digit_counter.sv
// Self-checking bench for hex_digit_counter: directed plan followed by
// randomized traffic against an arithmetic reference model.
module tb_hex_digit_counter;

  localparam int SEG_ACTIVE_LOW = 1;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Load;
  logic       Count_en;
  logic       Up;
  logic [3:0] Count_in;
  logic       DP;
  logic [7:0] Segment;
`ifdef HEX_DIGIT_COUNTER_TC_EN
  logic       Tc;
`endif

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  // Reference glyphs transcribed from the digit chart (active-low, DP off).
  localparam logic [7:0] REF_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  hex_digit_counter #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .Load    (Load),
    .Count_en(Count_en),
    .Up      (Up),
    .Count_in(Count_in),
    .DP      (DP),
    .Segment (Segment)
`ifdef HEX_DIGIT_COUNTER_TC_EN
    ,
    .Tc      (Tc)
`endif
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] expected_seg(input int value, input logic dp);
    logic [7:0] s;
    s = REF_GLYPH[value % 16];
    if (dp) s[7] = 1'b0;
    if (SEG_ACTIVE_LOW == 0) s = ~s;
    return s;
  endfunction

  function automatic int next_count(input int cur);
    if (!nReset)      return 0;
    if (Load)         return int'(Count_in);
    if (!Count_en)    return cur;
    if (Up)           return (cur + 1) % 16;
    return (cur + 15) % 16;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string tag);
    logic [7:0] exp;
    exp_q.push_back(expected_seg(model_count, DP));
    exp = exp_q.pop_front();
    checks++;
    assert (Segment === exp) else begin
      errors++;
      $error("FAIL %s: Segment=%h expected=%h (count model=%0d)", tag, Segment, exp, model_count);
    end
`ifdef HEX_DIGIT_COUNTER_TC_EN
    begin
      logic exp_tc;
      exp_tc = nReset && Count_en && !Load &&
               ((Up && model_count == 15) || (!Up && model_count == 0));
      checks++;
      assert (Tc === exp_tc) else begin
        errors++;
        $error("FAIL %s_tc: Tc=%b expected=%b", tag, Tc, exp_tc);
      end
    end
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ld, input logic en, input logic up,
                       input logic [3:0] cin, input logic dp);
    Load = ld; Count_en = en; Up = up; Count_in = cin; DP = dp;
  endtask

  task automatic set_reset(input logic n);
    nReset = n;
    if (!n) model_count = 0;
  endtask

  // One rising edge; model advances on the edge, outputs checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge Clk);
    model_count = next_count(model_count);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    set_reset(1'b0);
    @(negedge Clk);
    check_outputs("reset_async");
    tick("reset_hold1");
    tick("reset_hold2");
    set_reset(1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    tick("reset_release_idle");

    drive(1'b1, 1'b0, 1'b1, 4'h5, 1'b0);
    tick("load_5");
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) tick("hold_5");

    drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 12; i++) tick("count_up_wrap");
    drive(1'b1, 1'b1, 1'b1, 4'h9, 1'b0);
    tick("load_beats_en_up");
    drive(1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    tick("load_beats_en_down");

    drive(1'b1, 1'b0, 1'b0, 4'hC, 1'b0);
    tick("load_C");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) tick("count_down");
    drive(1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    tick("load_1");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) tick("count_down_wrap");

    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    #1 check_outputs("dp_on_comb");
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    #1 check_outputs("dp_off_comb");

    drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    tick("up_before_reset");
    tick("up_before_reset");
    #2 set_reset(1'b0);
    #1 check_outputs("async_reset_mid");
    @(negedge Clk);
    set_reset(1'b1);
    for (int i = 0; i < 16; i++) tick("up_16_after_reset");

    // Randomized traffic with occasional mid-cycle async resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom));
      #1 check_outputs("rand_comb");
      if ($urandom_range(0, 24) == 0) begin
        DP = 1'b0;
        set_reset(1'b0);
        #1 check_outputs("rand_async_reset");
        tick("rand_in_reset");
        set_reset(1'b1);
      end else begin
        tick("rand_edge");
      end
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case a task ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
